// File: rtl/ula_port.sv
// Spectrum ULA control: port 0xFE OUT latch, IN byte assembly, EAR synchroniser,
// frame counter with fixed-width interrupt pulse and FLASH phase.
module ula_port #(
  parameter int unsigned FRAME_CLKS = 500000,
  parameter int unsigned INT_CLKS   = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        n_iorq,
  input  logic        n_rd,
  input  logic        n_wr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic [4:0]  key_data,
  input  logic        ear_in,
  output logic        io_sel,
  output logic [7:0]  io_dout,
  output logic [2:0]  border,
  output logic        mic,
  output logic        speaker,
  output logic        int_n,
  output logic        flash
);

  localparam int unsigned FW = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
  localparam logic [FW-1:0] FCNT_LAST    = FW'(FRAME_CLKS - 1);
  localparam logic [FW-1:0] FCNT_INT_END = FW'(INT_CLKS);

  logic          wr_io;
  logic          write_ev;
  logic          wrap;
  logic          wr_io_q;
  logic          ear_meta_q, ear_sync_q;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [4:0]    fnum_q, fnum_d;
  logic          int_n_q, int_n_d;
  logic [2:0]    border_q, border_d;
  logic          mic_q, mic_d;
  logic          speaker_q, speaker_d;

  // Only address bit 0 and data bits 4:0 participate in the decode/latch.
  logic unused_bits;
  assign unused_bits = ^{cpu_addr[15:1], cpu_dout[7:5]};

  always_comb begin
    wr_io     = !n_iorq && !n_wr && !cpu_addr[0];
    io_sel    = !n_iorq && !n_rd && !cpu_addr[0];
    write_ev  = wr_io && !wr_io_q;
    wrap      = (fcnt_q == FCNT_LAST);
    fcnt_d    = wrap ? '0 : fcnt_q + 1'b1;
    fnum_d    = wrap ? fnum_q + 5'd1 : fnum_q;

    int_n_d   = int_n_q;
    if (wrap) begin
      int_n_d = 1'b0;
    end else if (fcnt_d == FCNT_INT_END) begin
      int_n_d = 1'b1;
    end

    border_d  = border_q;
    mic_d     = mic_q;
    speaker_d = speaker_q;
    if (write_ev) begin
      border_d  = cpu_dout[2:0];
      mic_d     = cpu_dout[3];
      speaker_d = cpu_dout[4];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_io_q    <= 1'b0;
      ear_meta_q <= 1'b0;
      ear_sync_q <= 1'b0;
      fcnt_q     <= '0;
      fnum_q     <= '0;
      int_n_q    <= 1'b1;
      border_q   <= '0;
      mic_q      <= 1'b0;
      speaker_q  <= 1'b0;
    end else begin
      wr_io_q    <= wr_io;
      ear_meta_q <= ear_in;
      ear_sync_q <= ear_meta_q;
      fcnt_q     <= fcnt_d;
      fnum_q     <= fnum_d;
      int_n_q    <= int_n_d;
      border_q   <= border_d;
      mic_q      <= mic_d;
      speaker_q  <= speaker_d;
    end
  end

  assign io_dout = {1'b1, ear_sync_q, 1'b1, key_data};
  assign border  = border_q;
  assign mic     = mic_q;
  assign speaker = speaker_q;
  assign int_n   = int_n_q;
  // fnum_q is itself a register, so its MSB is the registered FLASH phase.
  assign flash   = fnum_q[4];

endmodule

// File: tb/tb_ula_port.sv
// Bench for ula_port: directed scenarios plus random bus traffic, checked
// against a time-based reference model.
module tb_ula_port;

  localparam int unsigned FRAME = 100;
  localparam int unsigned INTW  = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        n_iorq, n_rd, n_wr;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic [4:0]  key_data;
  logic        ear_in;
  logic        io_sel;
  logic [7:0]  io_dout;
  logic [2:0]  border;
  logic        mic, speaker, int_n, flash;

  always #5 clk = ~clk;

  ula_port #(
    .FRAME_CLKS(FRAME),
    .INT_CLKS  (INTW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .n_iorq  (n_iorq),
    .n_rd    (n_rd),
    .n_wr    (n_wr),
    .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout),
    .key_data(key_data),
    .ear_in  (ear_in),
    .io_sel  (io_sel),
    .io_dout (io_dout),
    .border  (border),
    .mic     (mic),
    .speaker (speaker),
    .int_n   (int_n),
    .flash   (flash)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Model: t = clocks since reset release; port latch and EAR sample history.
  int unsigned t = 0;
  logic [2:0]  m_border = '0;
  logic        m_mic = 1'b0, m_spk = 1'b0, m_prev_wr = 1'b0;
  logic [1:0]  m_ear = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0d)", tag, act, exp, t);
    end
  endtask

  function automatic logic exp_int_n();
    return !(t >= FRAME && (t % FRAME) < INTW);
  endfunction

  function automatic logic exp_flash();
    return ((t / FRAME) % 32) >= 16;
  endfunction

  task automatic tick();
    logic wr;
    @(posedge clk);
    if (reset) begin
      t = 0; m_border = '0; m_mic = 1'b0; m_spk = 1'b0; m_prev_wr = 1'b0; m_ear = '0;
    end else begin
      t++;
      wr = !n_iorq && !n_wr && !cpu_addr[0];
      if (wr && !m_prev_wr) begin
        m_border = cpu_dout[2:0];
        m_mic    = cpu_dout[3];
        m_spk    = cpu_dout[4];
      end
      m_prev_wr = wr;
      m_ear = {m_ear[0], ear_in};
    end
    #1;
  endtask

  task automatic check_all();
    logic sel;
    sel = !n_iorq && !n_rd && !cpu_addr[0];
    check_eq("border",  32'(border),  32'(m_border));
    check_eq("mic",     32'(mic),     32'(m_mic));
    check_eq("speaker", 32'(speaker), 32'(m_spk));
    check_eq("int_n",   32'(int_n),   32'(exp_int_n()));
    check_eq("flash",   32'(flash),   32'(exp_flash()));
    check_eq("io_sel",  32'(io_sel),  32'(sel));
    check_eq("io_dout", 32'(io_dout), 32'({1'b1, m_ear[1], 1'b1, key_data}));
  endtask

  task automatic bus_idle();
    n_iorq = 1'b1; n_rd = 1'b1; n_wr = 1'b1;
    cpu_addr = 16'hFFFF; cpu_dout = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_idle();
    tick();
    tick();
    check_all();
    check_eq("rst_int_n",  32'(int_n),  32'd1);
    check_eq("rst_border", 32'(border), 32'd0);
    check_eq("rst_flash",  32'(flash),  32'd0);
    reset = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    n_iorq = 1'b0; n_wr = 1'b0; cpu_addr = a; cpu_dout = d;
    tick();
    check_all();
    bus_idle();
    tick();
    check_all();
  endtask

  initial begin
    key_data = 5'h1F;
    ear_in   = 1'b0;
    do_reset();

    // OUT latch with a long strobe: one latch only.
    n_iorq = 1'b0; n_wr = 1'b0; cpu_addr = 16'h00FE; cpu_dout = 8'h1D;
    tick();
    check_eq("out_border", 32'(border),  32'd5);
    check_eq("out_mic",    32'(mic),     32'd1);
    check_eq("out_spk",    32'(speaker), 32'd1);
    repeat (4) begin tick(); check_all(); end
    cpu_dout = 8'h00;
    repeat (3) begin tick(); check_all(); end
    check_eq("hold_border", 32'(border), 32'd5);
    n_iorq = 1'b1; n_wr = 1'b1;
    tick(); check_all();
    n_iorq = 1'b0; n_wr = 1'b0;
    tick(); check_all();
    check_eq("rearm_border", 32'(border),  32'd0);
    check_eq("rearm_spk",    32'(speaker), 32'd0);
    bus_idle(); tick(); check_all();

    // Partial decode on address bit 0.
    cpu_write(16'h12FF, 8'h07);
    check_eq("odd_addr_border", 32'(border), 32'd0);
    cpu_write(16'h7FFE, 8'h07);
    check_eq("even_addr_border", 32'(border), 32'd7);

    // IN path.
    n_iorq = 1'b0; n_rd = 1'b0; cpu_addr = 16'hFBFE; key_data = 5'b11110; ear_in = 1'b1;
    repeat (3) begin tick(); check_all(); end
    check_eq("in_sel",    32'(io_sel),  32'd1);
    check_eq("in_dout_1", 32'(io_dout), 32'hFE);
    ear_in = 1'b0;
    repeat (3) begin tick(); check_all(); end
    check_eq("in_dout_0", 32'(io_dout), 32'hBE);
    cpu_addr = 16'hFBFF;
    #1;
    check_eq("in_sel_odd", 32'(io_sel), 32'd0);
    bus_idle(); key_data = 5'h1F;

    // Interrupt cadence and FLASH phase over 33 frames.
    do_reset();
    for (int i = 0; i < 3300; i++) begin
      tick();
      check_all();
      case (t)
        99:   check_eq("int_pre",      32'(int_n), 32'd1);
        100:  check_eq("int_fall1",    32'(int_n), 32'd0);
        104:  check_eq("int_low_last", 32'(int_n), 32'd0);
        105:  check_eq("int_rise",     32'(int_n), 32'd1);
        200:  check_eq("int_fall2",    32'(int_n), 32'd0);
        1599: check_eq("flash_pre",    32'(flash), 32'd0);
        1600: check_eq("flash_rise",   32'(flash), 32'd1);
        3199: check_eq("flash_hi",     32'(flash), 32'd1);
        3200: check_eq("flash_fall",   32'(flash), 32'd0);
        default: ;
      endcase
    end

    // Reset during the third low clock of the interrupt pulse.
    do_reset();
    cpu_write(16'h00FE, 8'h03);
    check_eq("mid_border_set", 32'(border), 32'd3);
    while (t < 102) begin tick(); check_all(); end
    check_eq("mid_int_low", 32'(int_n), 32'd0);
    reset = 1'b1;
    tick(); check_all();
    check_eq("mid_rst_int_n",  32'(int_n),  32'd1);
    check_eq("mid_rst_border", 32'(border), 32'd0);
    reset = 1'b0;
    repeat (99) begin tick(); check_all(); end
    check_eq("mid_int_pre", 32'(int_n), 32'd1);
    tick(); check_all();
    check_eq("mid_int_fall", 32'(int_n), 32'd0);

    // Write event landing on the wrap cycle.
    do_reset();
    while (t < 99) begin tick(); check_all(); end
    n_iorq = 1'b0; n_wr = 1'b0; cpu_addr = 16'h00FE; cpu_dout = 8'h02;
    tick(); check_all();
    check_eq("sim_border", 32'(border), 32'd2);
    check_eq("sim_int_n",  32'(int_n),  32'd0);
    bus_idle();

    // Random bus traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 149) == 0);
      n_iorq   = ($urandom_range(0, 9) < 3);
      n_rd     = $urandom_range(0, 1) == 1;
      n_wr     = $urandom_range(0, 1) == 1;
      cpu_addr = 16'($urandom);
      cpu_dout = 8'($urandom);
      key_data = 5'($urandom);
      ear_in   = $urandom_range(0, 1) == 1;
      #1;
      check_eq("rnd_io_sel", 32'(io_sel), 32'(!n_iorq && !n_rd && !cpu_addr[0]));
      tick();
      check_all();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
